// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_DW = 32;
  localparam int FETCH_AW = 16;

  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam int          INSTR_BYTES = 4;

  // Default-width entry; fetch_stage overrides the FIFO entry type to match its own parameters.
  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  parameter int  CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; only pointers and count carry meaning.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC, imem issue with FIFO credit, prefetch buffer and redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] fpc, tag_pc;
  logic                     inflight;
  logic [CW-1:0]            count;
  logic [CW:0]              occ;
  logic                     full, empty;
  logic                     issue, resp_vld, push, pop;
  entry_t                   resp, head, sel;

  // Outstanding request counts against the FIFO so its response always has a slot.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue    = !rst && !redirect && (occ < (CW+1)'(DEPTH));
  assign imem_req = issue;
  assign imem_addr = fpc;

  assign resp_vld = inflight && !redirect && !rst;
  assign resp     = '{pc: tag_pc, instr: imem_rdata};
  assign pop      = !empty && out_ready && !redirect;

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp       = resp_vld && empty;
  assign push      = resp_vld && !full && !(byp && out_ready);
  assign out_valid = !empty || byp;
  assign sel       = byp ? resp : head;
`else
  assign push      = resp_vld && !full;
  assign out_valid = !empty;
  assign sel       = head;
`endif

  assign out_instr = out_valid ? sel.instr : DATA_WIDTH'(NOP_INSTR);
  assign out_pc    = out_valid ? sel.pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      fpc      <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fpc    <= fpc + ADDRESS_WIDTH'(INSTR_BYTES);
        tag_pc <= fpc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .CW      (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .din   (resp),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing scenarios plus randomized traffic against a stream-level model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [15:0] out_pc;

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(16), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a} ^ 32'h1234_0013;
  endfunction

  // Synchronous instruction memory; garbage when not requested.
  always @(posedge clk) imem_rdata <= imem_req ? memf(imem_addr) : $urandom();

  int n_chk = 0, n_pass = 0, req_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Stream model: decode must see consecutive PCs from the last restart point, each with its
  // memory word; requests run sequentially from the same point; outstanding work never exceeds DEPTH.
  logic [15:0] exp_pc = RPC, exp_req = RPC;
  int outst = 0, run = 0;

  always @(negedge clk) begin
    if (imem_req === 1'b1) req_cnt++;
    if (rst || redirect) chk("req_blocked", {31'b0, imem_req}, 32'd0);
    else begin
      chk("credit", {31'b0, (outst + int'(imem_req)) <= DEPTH}, 32'd1);
      if (imem_req) chk("req_addr", {16'b0, imem_addr}, {16'b0, exp_req});
    end
    if (out_valid) begin
      chk("out_pc", {16'b0, out_pc}, {16'b0, exp_pc});
      chk("out_instr", out_instr, memf(out_pc));
    end else begin
      chk("idle_instr", out_instr, NOP_INSTR);
      chk("idle_pc", {16'b0, out_pc}, 32'd0);
    end
    if (run >= 4) chk("throughput", {31'b0, out_valid}, 32'd1);

    if (rst) begin
      exp_pc = RPC; exp_req = RPC; outst = 0; run = 0;
    end else if (redirect) begin
      exp_pc = {redirect_pc[15:2], 2'b00}; exp_req = exp_pc; outst = 0; run = 0;
    end else begin
      if (imem_req) begin exp_req += 16'd4; outst++; end
      if (out_valid && out_ready) begin exp_pc += 16'd4; outst--; end
      run = out_ready ? run + 1 : 0;
    end
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, NOP_INSTR);
    chk("rst_pc", {16'b0, out_pc}, 32'd0);

    // Startup stream from RESET_PC.
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t0_req", {31'b0, imem_req}, 32'd1);
    chk("t0_addr", {16'b0, imem_addr}, {16'b0, RPC});
    repeat (LAT - 1) begin
      @(negedge clk); chk("pre_valid", {31'b0, out_valid}, 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_pc", {16'b0, out_pc}, 32'(RPC + 16'(4 * i)));
      chk("stream_instr", out_instr, memf(RPC + 16'(4 * i)));
    end

    // Backpressure: restart at 0x200 with decode stalled.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0200; out_ready = 1'b0;
    @(posedge clk); #1 redirect = 1'b0; base = req_cnt;
    repeat (10) @(posedge clk);
    #1 chk("bp_reqs", 32'(req_cnt - base), 32'(DEPTH));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head", {16'b0, out_pc}, 32'h0200);
    chk("bp_noreq", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_resume", {31'b0, imem_req}, 32'd1);
    chk("bp_resume_addr", {16'b0, imem_addr}, 32'h0210);

    // Redirect with 3 buffered, one in flight, and a handshake in the same cycle.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0102; out_ready = 1'b1;
    @(negedge clk);
    chk("rd_hs_pc", {16'b0, out_pc}, 32'h0204);
    @(posedge clk); #1 redirect = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("rd_req", {31'b0, imem_req}, 32'd1);
        chk("rd_addr", {16'b0, imem_addr}, 32'h0100);
      end
      if (c <= LAT) chk("rd_flushed", {31'b0, out_valid}, 32'd0);
      else begin
        chk("rd_valid", {31'b0, out_valid}, 32'd1);
        chk("rd_pc", {16'b0, out_pc}, 32'h0100);
      end
    end

    // Address wrap, also with misaligned target.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(posedge clk); #1 redirect = 1'b0;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c == 1) chk("wrap_a0", {16'b0, imem_addr}, 32'h0000FFFC);
      if (c == 2) chk("wrap_a1", {16'b0, imem_addr}, 32'h00000000);
      if (c == LAT + 1) chk("wrap_p0", {16'b0, out_pc}, 32'h0000FFFC);
      if (c == LAT + 2) chk("wrap_p1", {16'b0, out_pc}, 32'h00000000);
    end

    // Randomized traffic; the model process checks every cycle.
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      out_ready   = $urandom_range(0, 9) < 7;
      redirect    = $urandom_range(0, 24) == 0;
      redirect_pc = 16'($urandom());
      rst         = $urandom_range(0, 199) == 0;
    end
    @(posedge clk); #1 rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of decode and control. Owns the fetch PC and drives the synchronous instruction memory. Buffers returned instructions, each tagged with its PC, in a small prefetch FIFO. Hands them to decode over a valid/ready handshake, and flushes on a branch/jump redirect from execute.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDRESS_WIDTH, 16, byte-address width of PC
- RESET_PC, 0, fetch address after reset (word aligned)
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDRESS_WIDTH  fetch byte address (bits[1:0] always 0)
- imem_rdata  in  DATA_WIDTH  instruction; valid the cycle after imem_req
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDRESS_WIDTH  new fetch address
- out_valid  out  1  out_instr/out_pc valid
- out_ready  in  1  decode accepts
- out_instr  out  DATA_WIDTH  instruction at FIFO head
- out_pc  out  ADDRESS_WIDTH  PC of out_instr

## Operation
- State: fpc (next fetch address), inflight (1-bit, request outstanding), FIFO of {pc, instr}, count.
- Issue: imem_req = !rst && !redirect && (count + inflight < DEPTH); imem_addr = fpc. On issue: fpc <= fpc + 4 (wraps mod 2^ADDRESS_WIDTH), inflight <= 1, and the issued PC is captured for tagging.
- Response: in the cycle after issue, if !redirect, push {tagged pc, imem_rdata}; inflight clears unless a new issue occurs.
- Pop: out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- Redirect: priority over everything except rst. It clears the FIFO (count <= 0) and discards any response arriving this cycle. It ignores any pop this cycle; decode must not treat the handshake as accepted. It sets inflight <= 0 and fpc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}. Misaligned low bits are silently cleared.
- The credit rule guarantees no overflow. A push never occurs when full.
- While out_valid is 0, out_instr = 32'h00000013 (NOP) and out_pc = 0.

## Timing
- Reset values: imem_req 0 during rst, out_valid 0, out_instr NOP, out_pc 0, fpc RESET_PC, inflight 0, count 0.
- First request is in the first cycle with rst low (T0, addr RESET_PC). Data is pushed at end of T1. out_valid is asserted in T2.
- Latency is request to out_valid = 2 cycles. Sustained throughput is 1 instr/cycle with out_ready held high.
- Redirect penalty: redirect in cycle R, request to redirect_pc in R+1, out_valid in R+3.
- Backpressure: with out_ready low, requests stop once count + inflight = DEPTH. Requests resume the cycle after a pop frees a slot.
- rst asserted mid-operation: everything returns to reset values next cycle, and in-flight data is dropped.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and a response arrives, out_valid/out_instr/out_pc come combinationally from the response. Latency becomes 1 cycle and the redirect penalty R+2. If out_ready is high the response is consumed and not enqueued; otherwise it is pushed. Redirect still kills the bypassed response.
- Undefined: the registered-only path applies as specified above.

## Structure
- fetch_pkg holds the typedef fetch_entry_t {pc, instr}. It also holds the constants NOP_INSTR = 32'h00000013 and INSTR_BYTES = 4.
- One sub-module, fetch_fifo. It is a synchronous FIFO of fetch_entry_t with push/pop/flush, count, and full/empty, with flush taking priority over push/pop.
- fetch_stage holds fpc, inflight, the issue/credit logic and the optional bypass.

## Test plan
- Reset then out_ready=1, imem returns mem[addr>>2] → out_pc 0x0000,0x0004,0x0008… on consecutive cycles from T2, and instr matches memory.
- out_ready=0 for 10 cycles → exactly DEPTH (4) requests issued and count=4. One pop then frees exactly one new request the following cycle.
- Redirect to 0x0102 while 3 entries are buffered and a response is in flight → FIFO empty, next imem_addr=0x0100 at R+1, out_pc 0x0100 at R+3, no stale PC ever valid.
- Redirect in the same cycle as out_valid&&out_ready → that entry is flushed, and the next accepted instruction is the redirect target.
- fpc=0xFFFC, free-running → fetch addresses 0xFFFC then 0x0000, and out_pc wraps identically.
- With FETCH_BYPASS_EN, fetch after reset → out_valid in T1 with instr mem[0], and count stays 0 while out_ready=1.
